fetch_stage: RTL and testbench

Instruction-fetch stage of the rv32i core. It sits directly downstream of the write stage: it consumes the committed `pc` and its pipeline-control pulse, issues one word read on the instruction-memory port, and presents the fetched instruction to decode with a valid/ready handshake. It flags misaligned, bus-error and timed-out fetches so decode can trap.

---
 rtl/fetch_stage.sv | 186 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of the rv32i core. Takes the committed PC and its
// start pulse from the write stage, issues a single word read on the
// instruction-memory port, and hands the fetched word to decode through a
// valid/ready handshake. Misaligned, timed-out and bus-error fetches are
// presented as a NOP with a fault flag and cause so decode can trap.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   fetch_start_i     one-cycle start pulse, pc_i valid in the same cycle
//   pc_i              address to fetch
//   fetch_busy_o      high whenever the stage is not idle
//   imem_req_o        read request, held until granted
//   imem_addr_o       request address, stable while imem_req_o is high
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     read data valid this cycle
//   imem_rdata_i      read data
//   imem_err_i        bus error, qualified by imem_rvalid_i
//   inst_valid_o      instruction available to decode
//   inst_o            instruction word (NOP on any fault)
//   inst_pc_o         PC of inst_o
//   fetch_fault_o     presented instruction is faulted
//   fault_cause_o     00 none, 01 misaligned, 10 timeout, 11 bus error
//   decode_ready_i    decode accepts inst_o when high with inst_valid_o
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start_i,
  input  logic [31:0] pc_i,
  output logic        fetch_busy_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        fetch_fault_o,
  output logic [1:0]  fault_cause_o,
  input  logic        decode_ready_i
);

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [9:0]  TIMEOUT_LAST = 10'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  // Next-state logic. Every output is a register, so this block computes
  // the next value of each output alongside the FSM state. Anything not
  // touched in a state holds, which is what freezes the presented
  // instruction in HOLD and makes fetch_start and rvalid inert outside
  // IDLE and WAIT respectively.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cause_d = cause_q;

    case (state_q)
      IDLE: begin
        if (fetch_start_i) begin
          pc_d = pc_i;
          if (pc_i[1:0] != 2'b00) begin
            // Misaligned: never touches the bus, goes straight to decode.
            inst_d  = NOP;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            addr_d  = pc_i;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (imem_gnt_i) begin
          req_d   = 1'b0;
          cnt_d   = 10'd0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + 10'd1;
        // rvalid is checked first so a response in the timeout cycle wins.
        if (imem_rvalid_i) begin
          valid_d = 1'b1;
          state_d = HOLD;
          if (imem_err_i) begin
            inst_d  = NOP;
            fault_d = 1'b1;
            cause_d = CAUSE_BUSERR;
          end else begin
            inst_d  = imem_rdata_i;
            fault_d = 1'b0;
            cause_d = CAUSE_NONE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          inst_d  = NOP;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (decode_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously. Reset drops the
  // request immediately even if it was never granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 10'd0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= NOP;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign fetch_busy_o  = busy_q;
  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign inst_valid_o  = valid_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = pc_q;
  assign fetch_fault_o = fault_q;
  assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Each scenario task drives the
// memory and decode sides cycle by cycle and checks outputs #1 after the
// rising edge. Cycle k is the interval after the k-th edge following the
// start pulse; inputs set during cycle k are sampled at the edge ending it.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic [31:0] pc;
  logic        fetch_busy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        decode_ready;

  int checks;
  int errors;

  fetch_stage #(
    .RESET_PC(32'h0000_8000),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_start_i (fetch_start),
    .pc_i          (pc),
    .fetch_busy_o  (fetch_busy),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .imem_err_i    (imem_err),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .fetch_fault_o (fetch_fault),
    .fault_cause_o (fault_cause),
    .decode_ready_i(decode_ready)
  );

  // 10 time-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_start = 1'b0; pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    decode_ready = 1'b0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++; if (fault_cause !== 2'b00) begin errors++; $display("[TB] FAIL reset_cause: got %b expected 00", fault_cause); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 00000013", inst); end
    checks++; if (imem_addr !== 32'h0000_8000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00008000", imem_addr); end
    checks++; if (inst_pc !== 32'h0000_8000) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00008000", inst_pc); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", fetch_busy); end
    rst = 1'b1;
    step();
  endtask

  // Best case: grant in cycle 1, rvalid in cycle 2, valid in cycle 3.
  task automatic test_aligned();
    pc = 32'h0000_8000; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL aligned_req_c1: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0000_8000) begin errors++; $display("[TB] FAIL aligned_addr: got %h expected 00008000", imem_addr); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("[TB] FAIL aligned_busy_c1: got %b expected 1", fetch_busy); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL aligned_req_c2: got %b expected 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL aligned_valid_c2: got %b expected 0", inst_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL aligned_valid_c3: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h0050_0093) begin errors++; $display("[TB] FAIL aligned_inst: got %h expected 00500093", inst); end
    checks++; if (inst_pc !== 32'h0000_8000) begin errors++; $display("[TB] FAIL aligned_inst_pc: got %h expected 00008000", inst_pc); end
    checks++; if (fault_cause !== 2'b00) begin errors++; $display("[TB] FAIL aligned_cause: got %b expected 00", fault_cause); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL aligned_fault: got %b expected 0", fetch_fault); end
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL aligned_valid_c4: got %b expected 0", inst_valid); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL aligned_busy_c4: got %b expected 0", fetch_busy); end
  endtask

  // Grant in cycle 3, rvalid in cycle 7, valid in cycle 8. decode_ready is
  // raised in cycle 7 so the transfer happens on the first edge with valid.
  task automatic test_delayed();
    pc = 32'h0000_8010; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL delayed_req_c%0d: got %b expected 1", c, imem_req); end
      checks++; if (imem_addr !== 32'h0000_8010) begin errors++; $display("[TB] FAIL delayed_addr_c%0d: got %h expected 00008010", c, imem_addr); end
      imem_gnt = (c == 3);
      step();
    end
    imem_gnt = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL delayed_req_c%0d: got %b expected 0", c, imem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL delayed_valid_c%0d: got %b expected 0", c, inst_valid); end
      step();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113; decode_ready = 1'b1;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL delayed_valid_c8: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h00A0_0113) begin errors++; $display("[TB] FAIL delayed_inst: got %h expected 00a00113", inst); end
    checks++; if (inst_pc !== 32'h0000_8010) begin errors++; $display("[TB] FAIL delayed_inst_pc: got %h expected 00008010", inst_pc); end
    step();
    decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL delayed_valid_c9: got %b expected 0", inst_valid); end
  endtask

  // Misaligned PC: no request, faulted NOP valid in cycle 1.
  task automatic test_misaligned();
    pc = 32'h0000_8002; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL misalign_req: got %b expected 0", imem_req); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL misalign_valid: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL misalign_inst: got %h expected 00000013", inst); end
    checks++; if (fault_cause !== 2'b01) begin errors++; $display("[TB] FAIL misalign_cause: got %b expected 01", fault_cause); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL misalign_fault: got %b expected 1", fetch_fault); end
    checks++; if (inst_pc !== 32'h0000_8002) begin errors++; $display("[TB] FAIL misalign_inst_pc: got %h expected 00008002", inst_pc); end
    checks++; if (imem_addr !== 32'h0000_8010) begin errors++; $display("[TB] FAIL misalign_addr: got %h expected 00008010", imem_addr); end
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL misalign_release: got %b expected 0", inst_valid); end
  endtask

  // TIMEOUT=4, grant in cycle 1: WAIT occupies cycles 2..5, valid in cycle 6.
  task automatic test_timeout();
    pc = 32'h0000_8020; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_valid_c%0d: got %b expected 0", c, inst_valid); end
      step();
    end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_valid_c6: got %b expected 1", inst_valid); end
    checks++; if (fault_cause !== 2'b10) begin errors++; $display("[TB] FAIL timeout_cause: got %b expected 10", fault_cause); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL timeout_inst: got %h expected 00000013", inst); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL timeout_fault: got %b expected 1", fetch_fault); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL timeout_late_inst: got %h expected 00000013", inst); end
    checks++; if (fault_cause !== 2'b10) begin errors++; $display("[TB] FAIL timeout_late_cause: got %b expected 10", fault_cause); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_late_valid: got %b expected 1", inst_valid); end
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_release: got %b expected 0", inst_valid); end
  endtask

  // Bus error, then five cycles of back-pressure with an ignored start.
  task automatic test_bus_error_hold();
    pc = 32'h0000_8030; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = 32'h0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL buserr_valid: got %b expected 1", inst_valid); end
    checks++; if (fault_cause !== 2'b11) begin errors++; $display("[TB] FAIL buserr_cause: got %b expected 11", fault_cause); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL buserr_inst: got %h expected 00000013", inst); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL buserr_fault: got %b expected 1", fetch_fault); end
    pc = 32'h0000_8040;
    for (int i = 0; i < 5; i++) begin
      fetch_start = (i == 1);
      step();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid_%0d: got %b expected 1", i, inst_valid); end
      checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL hold_inst_%0d: got %h expected 00000013", i, inst); end
      checks++; if (fault_cause !== 2'b11) begin errors++; $display("[TB] FAIL hold_cause_%0d: got %b expected 11", i, fault_cause); end
      checks++; if (inst_pc !== 32'h0000_8030) begin errors++; $display("[TB] FAIL hold_inst_pc_%0d: got %h expected 00008030", i, inst_pc); end
      checks++; if (imem_addr !== 32'h0000_8030) begin errors++; $display("[TB] FAIL hold_addr_%0d: got %h expected 00008030", i, imem_addr); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_%0d: got %b expected 0", i, imem_req); end
    end
    fetch_start = 1'b0; decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %b expected 0", inst_valid); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_busy: got %b expected 0", fetch_busy); end
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_start_ignored: got %b expected 0", imem_req); end
  endtask

  // Asynchronous reset while in REQ, then a normal fetch afterwards.
  task automatic test_reset_mid_req();
    pc = 32'h0000_8050; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL midreset_req_before: got %b expected 1", imem_req); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req_async: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0000_8000) begin errors++; $display("[TB] FAIL midreset_addr: got %h expected 00008000", imem_addr); end
    checks++; if (inst_pc !== 32'h0000_8000) begin errors++; $display("[TB] FAIL midreset_inst_pc: got %h expected 00008000", inst_pc); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL midreset_inst: got %h expected 00000013", inst); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", fetch_busy); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", inst_valid); end
    step();
    rst = 1'b1;
    step();
    pc = 32'h0000_8060; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0; imem_gnt = 1'b1;
    checks++; if (imem_addr !== 32'h0000_8060) begin errors++; $display("[TB] FAIL after_reset_addr: got %h expected 00008060", imem_addr); end
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0493;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_valid: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h0000_0493) begin errors++; $display("[TB] FAIL after_reset_inst: got %h expected 00000493", inst); end
    checks++; if (inst_pc !== 32'h0000_8060) begin errors++; $display("[TB] FAIL after_reset_inst_pc: got %h expected 00008060", inst_pc); end
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL after_reset_release: got %b expected 0", inst_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_aligned();
    test_delayed();
    test_misaligned();
    test_timeout();
    test_bus_error_hold();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
